// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the 1-D CNN layer blocks.
// Holds the address-width helper and the parameter-loader state encoding.
package cnn1d_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    READY = 3'd3,
    DRAIN = 3'd4
  } conv1d_loader_state_t;

endpackage

// File: rtl/conv1d_param_loader_if.sv
// Parameter-RAM read side, parameter-register write side and layer gating of the loader.
// The master modport belongs to the loader, the slave modport to the surrounding layer.
interface conv1d_param_loader_if #(
  parameter int ADDRESS_WIDTH = 5
);
  logic [ADDRESS_WIDTH-1:0] ram_address;
  logic                     ram_rden;
  logic                     param_we;
  logic [ADDRESS_WIDTH-1:0] param_sel;
  logic                     params_valid;
  logic                     load_done;
  logic                     reload_req;
  logic                     datapath_busy;

  modport master (
    output ram_address, ram_rden, param_we, param_sel, params_valid, load_done,
    input  reload_req, datapath_busy
  );

  modport slave (
    input  ram_address, ram_rden, param_we, param_sel, params_valid, load_done,
    output reload_req, datapath_busy
  );
endinterface

// File: rtl/cnn1d_delay.sv
// Fixed-depth register delay line, async active-low reset; o_dat is i_dat delayed DEPTH cycles.
// No backpressure: shifts every cycle.
module cnn1d_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);
  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_dat = r_pipe[DEPTH-1];
endmodule

// File: rtl/conv1d_param_loader.sv
// Loads per-filter weight/bias words into the parameter registers, then raises params_valid.
// Runtime reload (READY -> DRAIN -> LOAD) only when CONV1D_PARAM_LOADER_RELOAD_EN is defined.
module conv1d_param_loader
  import cnn1d_pkg::*;
#(
  parameter int NUM_FILTERS   = 32,
  parameter int RAM_LATENCY   = 2,
  parameter int ADDRESS_WIDTH = (clog2(NUM_FILTERS) < 1) ? 1 : clog2(NUM_FILTERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  conv1d_param_loader_if.master bus
);
  localparam int CNT_W = (clog2(RAM_LATENCY + 1) < 1) ? 1 : clog2(RAM_LATENCY + 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = ADDRESS_WIDTH'(NUM_FILTERS - 1);
  localparam logic [CNT_W-1:0]         LAST_FLUSH = CNT_W'(RAM_LATENCY - 1);

  conv1d_loader_state_t     r_state;
  logic                     r_rden;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]         r_flush_cnt;
  logic                     r_valid;
  logic                     r_done;
  logic [ADDRESS_WIDTH:0]   w_dly_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rden      <= 1'b0;
      r_addr      <= '0;
      r_flush_cnt <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= LOAD;
          r_rden  <= 1'b1;
          r_addr  <= '0;
        end
        // Address holds at the last filter once reached; it never wraps.
        LOAD: begin
          if (r_addr == LAST_ADDR) begin
            r_state     <= FLUSH;
            r_rden      <= 1'b0;
            r_flush_cnt <= '0;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        FLUSH: begin
          if (r_flush_cnt == LAST_FLUSH) begin
            r_state <= READY;
            r_valid <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
`ifdef CONV1D_PARAM_LOADER_RELOAD_EN
        READY: begin
          if (bus.reload_req) begin
            r_state <= DRAIN;
            r_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (!bus.datapath_busy) begin
            r_state <= LOAD;
            r_rden  <= 1'b1;
            r_addr  <= '0;
          end
        end
`else
        READY: ;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

`ifndef CONV1D_PARAM_LOADER_RELOAD_EN
  wire w_unused = ^{bus.reload_req, bus.datapath_busy};
`endif

  // Read strobe/address ride the RAM latency to become the register write strobe/select.
  cnn1d_delay #(
    .WIDTH (ADDRESS_WIDTH + 1),
    .DEPTH (RAM_LATENCY)
  ) u_wr_dly (
    .clk   (clk),
    .rst_n (rst),
    .i_dat ({r_rden, r_addr}),
    .o_dat (w_dly_out)
  );

  assign bus.ram_address  = r_addr;
  assign bus.ram_rden     = r_rden;
  assign bus.param_we     = w_dly_out[ADDRESS_WIDTH];
  assign bus.param_sel    = w_dly_out[ADDRESS_WIDTH-1:0];
  assign bus.params_valid = r_valid;
  assign bus.load_done    = r_done;
endmodule

// File: tb/tb_conv1d_param_loader.sv
// Bench for conv1d_param_loader: N=32/L=2 instance with a write scoreboard plus an N=1/L=1 instance.
// Reload scenarios follow CONV1D_PARAM_LOADER_RELOAD_EN.
module tb_conv1d_param_loader;
  localparam int N  = 32;
  localparam int L  = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv1d_param_loader_if #(.ADDRESS_WIDTH(AW)) bus_a ();
  conv1d_param_loader_if #(.ADDRESS_WIDTH(1))  bus_b ();

  conv1d_param_loader #(.NUM_FILTERS(N), .RAM_LATENCY(L), .ADDRESS_WIDTH(AW)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.master)
  );
  conv1d_param_loader #(.NUM_FILTERS(1), .RAM_LATENCY(1), .ADDRESS_WIDTH(1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.master)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_ready_idle(input string tag);
    check({tag, "_valid"}, bus_a.params_valid, 1);
    check({tag, "_done"},  bus_a.load_done, 0);
    check({tag, "_rden"},  bus_a.ram_rden, 0);
    check({tag, "_we"},    bus_a.param_we, 0);
  endtask

  // Called on the negedge before load cycle 0; returns at the negedge of cycle N+L.
  task automatic run_load(input bit chk_b);
    for (int k = 0; k < N; k++) exp_q.push_back(k);
    for (int c = 0; c <= N + L; c++) begin
      @(negedge clk);
      check("rden", bus_a.ram_rden, c < N);
      if (c < N) check("addr", bus_a.ram_address, c);
      check("we", bus_a.param_we, (c >= L) && (c < L + N));
      if (bus_a.param_we) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else check("sel", bus_a.param_sel, exp_q.pop_front());
      end
      check("valid", bus_a.params_valid, c >= N + L);
      check("done",  bus_a.load_done, c == N + L);
      if (chk_b && c < 4) begin
        check("b_rden",  bus_b.ram_rden, c == 0);
        if (c == 0) check("b_addr", bus_b.ram_address, 0);
        check("b_we",    bus_b.param_we, c == 1);
        if (c == 1) check("b_sel", bus_b.param_sel, 0);
        check("b_valid", bus_b.params_valid, c >= 2);
        check("b_done",  bus_b.load_done, c == 2);
      end
    end
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    bus_a.reload_req = 1'b0; bus_a.datapath_busy = 1'b0;
    bus_b.reload_req = 1'b0; bus_b.datapath_busy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rden",  bus_a.ram_rden, 0);
    check("rst_addr",  bus_a.ram_address, 0);
    check("rst_we",    bus_a.param_we, 0);
    check("rst_sel",   bus_a.param_sel, 0);
    check("rst_valid", bus_a.params_valid, 0);
    check("rst_done",  bus_a.load_done, 0);
    check("rst_b_valid", bus_b.params_valid, 0);

    rst = 1'b1;
    run_load(1'b1);
    @(negedge clk);
    check_ready_idle("post_load");
    check("b_hold_valid", bus_b.params_valid, 1);

`ifdef CONV1D_PARAM_LOADER_RELOAD_EN
    bus_a.reload_req = 1'b1;
    bus_a.datapath_busy = 1'b1;
    @(negedge clk);
    bus_a.reload_req = 1'b0;
    check("drain_valid", bus_a.params_valid, 0);
    check("drain_rden",  bus_a.ram_rden, 0);
    repeat (4) begin
      @(negedge clk);
      check("busy_valid", bus_a.params_valid, 0);
      check("busy_rden",  bus_a.ram_rden, 0);
    end
    bus_a.datapath_busy = 1'b0;
    run_load(1'b0);

    // Request held through the whole load: only the READY-cycle sample matters.
    bus_a.reload_req = 1'b1;
    @(negedge clk);
    check("held_drain_valid", bus_a.params_valid, 0);
    check("held_drain_rden",  bus_a.ram_rden, 0);
    run_load(1'b0);
    @(negedge clk);
    check("held_redrain_valid", bus_a.params_valid, 0);
    check("held_redrain_rden",  bus_a.ram_rden, 0);
    bus_a.reload_req = 1'b0;
    run_load(1'b0);
    @(negedge clk);
    check_ready_idle("reload_end");
`else
    bus_a.reload_req = 1'b1;
    @(negedge clk);
    bus_a.reload_req = 1'b0;
    repeat (5) begin
      check_ready_idle("no_reload");
      @(negedge clk);
    end
`endif

    // Abort a load mid-way with an asynchronous reset.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c <= 10; c++) @(negedge clk);
    check("pre_abort_rden", bus_a.ram_rden, 1);
    check("pre_abort_addr", bus_a.ram_address, 10);
    rst = 1'b0;
    #1;
    check("abort_rden",  bus_a.ram_rden, 0);
    check("abort_addr",  bus_a.ram_address, 0);
    check("abort_we",    bus_a.param_we, 0);
    check("abort_sel",   bus_a.param_sel, 0);
    check("abort_valid", bus_a.params_valid, 0);
    check("abort_done",  bus_a.load_done, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    run_load(1'b1);
    @(negedge clk);
    check_ready_idle("restart_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/conv1d_param_loader.md
# conv1d_param_loader

Sequencing controller that loads per-filter weight and bias words from the convolution layer's parameter RAMs into the layer's per-filter parameter registers, then opens the layer's input handshake. It sits between the layer's weight/bias `sp_ram` instances and the `conv1d` array. It replaces free-running address counters with an explicit load/ready/drain state machine, and supports an optional runtime reload.

## Interface
- `NUM_FILTERS`, 32, number of filters; RAM depth and parameter register count.
- `RAM_LATENCY`, 2, cycles from `ram_address`/`ram_rden` to valid RAM `q`; must be ≥1.
- `ADDRESS_WIDTH`, `clog2(NUM_FILTERS)`, RAM address and filter index width; minimum 1.

Ports:
- `clk`  in  1  clock. One clock domain; all logic runs on `clk`.
- `rst`  in  1  reset, asynchronous and active-low.
- `ram_address`  out  `ADDRESS_WIDTH`  address shared by the weight and bias RAMs.
- `ram_rden`  out  1  read enable for both RAMs.
- `param_we`  out  1  write strobe for the parameter registers.
- `param_sel`  out  `ADDRESS_WIDTH`  filter index written when `param_we` is high.
- `params_valid`  out  1  all parameters loaded; ANDed into the layer's `ready_in` and `valid_in`.
- `load_done`  out  1  single-cycle pulse when a load completes.
- `reload_req`  in  1  request for a parameter reload (used only with the macro).
- `datapath_busy`  in  1  high while any `conv1d` pipeline holds in-flight data.

## Operation
- States: `IDLE`, `LOAD`, `FLUSH`, `READY`, `DRAIN`.
- Reset values: state `IDLE`; all outputs 0.
- `IDLE` → `LOAD` on the first `clk` edge after reset is released.
- `LOAD`:
  - `ram_rden`=1 and `ram_address`=k during the k-th `LOAD` cycle, k=0..`NUM_FILTERS`-1.
  - The address counter saturates and never wraps.
  - After address `NUM_FILTERS`-1, go to `FLUSH`.
- Write pipeline: a `RAM_LATENCY`-deep delay line carries (`rden`, `address`) to (`param_we`, `param_sel`). Exactly `NUM_FILTERS` writes occur per load, in ascending index order, with no gaps.
- `FLUSH`:
  - `ram_rden`=0.
  - Stay for `RAM_LATENCY` cycles, until the last write has been issued, then go to `READY`.
- `READY`: `params_valid`=1. `load_done`=1 in the first `READY` cycle only.
- `DRAIN` (reload only):
  - `params_valid`=0.
  - Go to `LOAD` in the cycle after `datapath_busy` is sampled low.
  - If `datapath_busy` is already low on entry, spend exactly 1 cycle in `DRAIN`.
- `reload_req` is honoured only in `READY`, and only with the macro. It is ignored and not queued in every other state.
- `NUM_FILTERS`=1 is legal: `LOAD` lasts 1 cycle.

## Timing
- Cycle 0 is the first `LOAD` cycle. Let N=`NUM_FILTERS` and L=`RAM_LATENCY`.
- `param_we` is high in cycles L..L+N-1, with `param_sel`=cycle-L.
- `params_valid` rises, and `load_done` pulses, in cycle N+L. For N=32, L=2 this is cycle 34.
- `reload_req` sampled high in `READY` at cycle t:
  - `params_valid`=0 from cycle t+1.
  - `LOAD` begins the cycle after `datapath_busy` is sampled low, at the earliest t+2.
- All outputs are registered; no combinational input-to-output paths.
- Asserting `rst` mid-operation immediately (asynchronously) clears all outputs and aborts the load. A full load restarts after release.

## Configuration
- Macro `CONV1D_PARAM_LOADER_RELOAD_EN`.
- Defined: `DRAIN` state present; `reload_req` behaves as described in Operation.
- Undefined:
  - `DRAIN` is not compiled.
  - `reload_req` and `datapath_busy` are ignored.
  - `READY` is terminal until reset, so exactly one load happens per reset.

## Structure
- Shared package `cnn1d_pkg` holds:
  - the existing `clog2`;
  - a new `conv1d_loader_state_t` enum (`IDLE`, `LOAD`, `FLUSH`, `READY`, `DRAIN`).
- Sub-module `cnn1d_delay`: parameterised width/depth register delay line with async active-low reset, used for the `rden`/`address` → `we`/`sel` pipeline.

## Test plan
- N=32, L=2, reset released → `ram_address` 0..31 in cycles 0..31; `param_we` in cycles 2..33 with `param_sel` 0..31; `params_valid` and `load_done` in cycle 34; `load_done` low in cycle 35.
- N=1, L=1 → one read at address 0; write in cycle 1; `params_valid` in cycle 2.
- Macro defined, `reload_req` pulsed in `READY` with `datapath_busy` high for 5 cycles → `params_valid` drops next cycle; `LOAD` starts the cycle after `busy` falls; full 32-entry reload; `params_valid` returns.
- Macro defined, `reload_req` held high during `LOAD` → ignored; exactly 32 writes. Reload starts only if `reload_req` is still high in `READY`.
- `rst` asserted at cycle 10 of `LOAD` → all outputs 0 immediately; after release, writes restart from `param_sel`=0.
- Macro undefined, `reload_req` pulsed in `READY` → no state change; `params_valid` stays 1; no `ram_rden`.
